// File: rtl/axi_pkg.sv
// Shared AXI4 constants, FSM state types and address/status helpers
// for the burst memory responder.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // Byte address to word index; low address bits drop out.
  function automatic logic [31:0] word_index(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    return (addr - base) >> 2;
  endfunction

  // Whole-burst status. A start below base wraps to a huge index,
  // so one unsigned compare covers both ends of the window.
  function automatic logic [1:0] burst_status(
    input logic [31:0] word,
    input logic [31:0] depth,
    input logic [7:0]  len,
    input logic [2:0]  size,
    input logic [1:0]  burst
  );
    logic [32:0] last;
    last = {1'b0, word} +
      ((burst == BURST_FIXED) ? 33'd0 : {25'd0, len});
    if (word >= depth || last >= {1'b0, depth})
      return RESP_DECERR;
    if (size != SIZE_WORD ||
        (burst != BURST_FIXED && burst != BURST_INCR))
      return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_burst_mem_responder_bram.sv
// bram_1w1r: one byte-enabled write port, one registered read port.
// Ports: clk; we/waddr/wstrb/wdata write; re/raddr read, rdata registered.
module bram_1w1r #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wstrb,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Both ports update on the same edge with non-blocking writes,
  // so a colliding read sees the old word (read-first).
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b])
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4_burst_mem_responder.sv
// AXI4 burst slave memory: independent write (AW/W/B) and read (AR/R) FSMs
// over bram_1w1r; ports s_axi_*, plus wr/rd burst counters and err_sticky.
module axi4_burst_mem_responder
  import axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [15:0] wr_burst_cnt,
  output logic [15:0] rd_burst_cnt,
  output logic        err_sticky
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);
  localparam logic [31:0] POISON = 32'hDEAD_BEEF;

  wr_state_e w_state, w_next;
  rd_state_e r_state, r_next;

  logic [AW-1:0] w_word, r_word, raddr;
  logic [7:0]    w_len, w_beat, r_len, r_beat, r_off;
  logic          w_fixed, w_over, r_fixed, r_vld;
  logic [1:0]    w_resp, r_resp;
  logic [31:0]   aw_word, ar_word, ram_q;
  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs, r_done;
  logic          w_mism, we, re;

  assign aw_word = word_index(s_axi_awaddr, BASE_ADDR);
  assign ar_word = word_index(s_axi_araddr, BASE_ADDR);

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign b_hs   = s_axi_bvalid && s_axi_bready;
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign r_hs   = s_axi_rvalid && s_axi_rready;
  assign r_done = r_hs && (r_beat == r_len);

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && s_axi_wlast) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_done) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Outputs; rst masks handshakes so an abort takes effect at once.
  always_comb begin
    s_axi_awready = !rst && (w_state == W_IDLE);
    s_axi_wready  = !rst && (w_state == W_DATA);
    s_axi_bvalid  = !rst && (w_state == W_RESP);
    s_axi_bresp   = w_resp;
    s_axi_arready = !rst && (r_state == R_IDLE);
    s_axi_rvalid  = !rst && r_vld;
    s_axi_rresp   = s_axi_rvalid ? r_resp : RESP_OKAY;
    s_axi_rlast   = s_axi_rvalid && (r_beat == r_len);
    s_axi_rdata   = '0;
    if (s_axi_rvalid)
      s_axi_rdata = (r_resp == RESP_OKAY) ? ram_q : POISON;
  end

  // wlast early, or missing on the final beat. Once past the final
  // beat, any further wlast closes the burst as a mismatch too.
  assign w_mism = w_hs && (s_axi_wlast ?
    (w_over || w_beat != w_len) :
    (!w_over && w_beat == w_len));

  assign we = w_hs && (w_resp == RESP_OKAY) && !w_over;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_word       <= '0;
      w_len        <= '0;
      w_beat       <= '0;
      w_fixed      <= 1'b0;
      w_over       <= 1'b0;
      w_resp       <= RESP_OKAY;
      wr_burst_cnt <= '0;
    end else begin
      if (aw_hs) begin
        w_word  <= AW'(aw_word);
        w_len   <= s_axi_awlen;
        w_beat  <= '0;
        w_fixed <= (s_axi_awburst == BURST_FIXED);
        w_over  <= 1'b0;
        w_resp  <= burst_status(aw_word, DEPTH, s_axi_awlen,
                                s_axi_awsize, s_axi_awburst);
      end
      if (w_hs) begin
        w_beat <= w_beat + 8'd1;
        if (!w_fixed)
          w_word <= w_word + AW'(1);
        if (!s_axi_wlast && w_beat == w_len)
          w_over <= 1'b1;
        if (w_mism && w_resp == RESP_OKAY)
          w_resp <= RESP_SLVERR;
      end
      if (b_hs)
        wr_burst_cnt <= wr_burst_cnt + 16'd1;
    end
  end

  // Read pipeline: the first fetch issues on entry to R_DATA, each
  // later fetch on the handshake of the beat before it, so RAM output
  // only changes when a beat is consumed and holds through stalls.
  assign re = (r_state == R_DATA) && (!r_vld || (r_hs && !r_done));
  assign r_off = r_vld ? r_beat + 8'd1 : 8'd0;
  assign raddr = r_fixed ? r_word : r_word + AW'(r_off);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word       <= '0;
      r_len        <= '0;
      r_beat       <= '0;
      r_fixed      <= 1'b0;
      r_vld        <= 1'b0;
      r_resp       <= RESP_OKAY;
      rd_burst_cnt <= '0;
    end else begin
      if (ar_hs) begin
        r_word  <= AW'(ar_word);
        r_len   <= s_axi_arlen;
        r_beat  <= '0;
        r_fixed <= (s_axi_arburst == BURST_FIXED);
        r_vld   <= 1'b0;
        r_resp  <= burst_status(ar_word, DEPTH, s_axi_arlen,
                                s_axi_arsize, s_axi_arburst);
      end else if (r_done) begin
        r_vld <= 1'b0;
      end else if (r_state == R_DATA) begin
        r_vld <= 1'b1;
      end
      if (r_hs)
        r_beat <= r_beat + 8'd1;
      if (r_done)
        rd_burst_cnt <= rd_burst_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      err_sticky <= 1'b0;
    else if ((b_hs && w_resp != RESP_OKAY) ||
             (r_hs && r_resp != RESP_OKAY))
      err_sticky <= 1'b1;
  end

  bram_1w1r #(
    .DEPTH (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (w_word),
    .wstrb (s_axi_wstrb),
    .wdata (s_axi_wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_axi4_burst_mem_responder.sv
// Scoreboard bench for axi4_burst_mem_responder: expected B/R values are
// queued when a burst is issued and popped as the DUT responds.
module tb_axi4_burst_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'b010;
  logic [1:0]  awburst = 2'b01;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'b010;
  logic [1:0]  arburst = 2'b01;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [15:0] wr_cnt, rd_cnt;
  logic        err;

  int total = 0;
  int bad = 0;
  int exp_wr = 0;
  int exp_rd = 0;

  logic [31:0] model [256];
  logic [31:0] wdat [16];
  logic [31:0] rq [$];
  logic [1:0]  rsq [$];
  logic [1:0]  bq [$];

  axi4_burst_mem_responder dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awaddr  (awaddr),
    .s_axi_awlen   (awlen),
    .s_axi_awsize  (awsize),
    .s_axi_awburst (awburst),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_arsize  (arsize),
    .s_axi_arburst (arburst),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rlast   (rlast),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .wr_burst_cnt  (wr_cnt),
    .rd_burst_cnt  (rd_cnt),
    .err_sticky    (err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Drive AW and nb W beats; wlast on beat last_at (-1 = never).
  task automatic axi_write(input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bt,
                           input logic [3:0] st, input int nb,
                           input int last_at);
    int to;
    @(posedge clk); #1;
    awaddr = a; awlen = len; awsize = sz; awburst = bt; awvalid = 1'b1;
    to = 0;
    @(negedge clk);
    while (!awready && to < 50) begin @(negedge clk); to++; end
    if (!awready) begin
      total++; bad++;
      $display("FAIL aw_timeout got=%b want=1", awready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int n = 0; n < nb; n++) begin
      wdata = wdat[n]; wstrb = st; wlast = (n == last_at); wvalid = 1'b1;
      to = 0;
      @(negedge clk);
      while (!wready && to < 50) begin @(negedge clk); to++; end
      if (!wready) begin
        total++; bad++;
        $display("FAIL w_timeout beat=%0d got=%b want=1", n, wready);
      end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  // Expect bvalid for 'hold' cycles with bready low, then handshake.
  task automatic check_b(input int hold);
    logic [1:0] er;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      total++;
      if (bvalid !== 1'b1) begin
        bad++;
        $display("FAIL b_valid cyc=%0d got=%b want=1", i, bvalid);
      end
    end
    @(posedge clk); #1;
    bready = 1'b1;
    @(negedge clk);
    er = (bq.size() > 0) ? bq.pop_front() : 2'bxx;
    total++;
    if (bvalid !== 1'b1 || bresp !== er) begin
      bad++;
      $display("FAIL b_resp got=%b/%b want=1/%b", bvalid, bresp, er);
    end
    @(posedge clk); #1;
    bready = 1'b0;
    exp_wr++;
    @(negedge clk);
    total++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wr_cnt !== 16'(exp_wr)) begin
      bad++;
      $display("FAIL b_done bvalid=%b awready=%b cnt=%0d want 0/1/%0d",
               bvalid, awready, wr_cnt, exp_wr);
    end
  endtask

  // Issue AR and consume len+1 beats against rq/rsq.
  task automatic axi_read(input logic [31:0] a, input logic [7:0] len,
                          input logic [1:0] bt, input bit rnd);
    int to, cyc, beats, first, lastc;
    bit stall;
    logic [31:0] pd, ed;
    logic [1:0] pr, er;
    logic pl;
    @(posedge clk); #1;
    araddr = a; arlen = len; arsize = 3'b010; arburst = bt; arvalid = 1'b1;
    to = 0;
    @(negedge clk);
    while (!arready && to < 50) begin @(negedge clk); to++; end
    if (!arready) begin
      total++; bad++;
      $display("FAIL ar_timeout got=%b want=1", arready);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc = 0; beats = 0; stall = 0; first = 0; lastc = 0;
    pd = '0; pr = '0; pl = 1'b0;
    while (beats <= int'(len) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc <= 2) begin
        total++;
        if (rvalid !== (cyc == 2)) begin
          bad++;
          $display("FAIL r_latency cyc=%0d got=%b want=%b",
                   cyc, rvalid, cyc == 2);
        end
      end
      if (stall) begin
        total++;
        if (rdata !== pd || rresp !== pr || rlast !== pl) begin
          bad++;
          $display("FAIL r_stable got=%h/%b/%b want=%h/%b/%b",
                   rdata, rresp, rlast, pd, pr, pl);
        end
      end
      if (rvalid && rready) begin
        ed = (rq.size() > 0) ? rq.pop_front() : 32'hx;
        er = (rsq.size() > 0) ? rsq.pop_front() : 2'bxx;
        total++;
        if (rdata !== ed || rresp !== er || rlast !== (beats == int'(len))) begin
          bad++;
          $display("FAIL r_beat%0d got=%h/%b/%b want=%h/%b/%b", beats,
                   rdata, rresp, rlast, ed, er, beats == int'(len));
        end
        if (beats == 0) first = cyc;
        lastc = cyc;
        beats++;
      end
      stall = rvalid && !rready;
      pd = rdata; pr = rresp; pl = rlast;
      @(posedge clk); #1;
      if (rnd) rready = 1'($urandom_range(0, 1));
    end
    rready = 1'b0;
    if (beats <= int'(len)) begin
      total++; bad++;
      $display("FAIL r_timeout got=%0d want=%0d beats", beats, len + 1);
    end
    if (!rnd) begin
      total++;
      if (lastc - first != int'(len)) begin
        bad++;
        $display("FAIL r_rate got=%0d want=%0d cycles", lastc - first, len);
      end
    end
    exp_rd++;
    @(negedge clk);
    total++;
    if (rd_cnt !== 16'(exp_rd) || arready !== 1'b1) begin
      bad++;
      $display("FAIL r_done cnt=%0d arready=%b want %0d/1", rd_cnt, arready, exp_rd);
    end
  endtask

  task automatic test_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++;
    if ({awready, wready, bvalid, bresp, arready, rvalid, rlast, rresp}
        !== 10'b0 || rdata !== 32'h0 || wr_cnt !== 16'h0 ||
        rd_cnt !== 16'h0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals aw=%b w=%b b=%b br=%b ar=%b r=%b rl=%b rr=%b rd=%h c=%0d/%0d e=%b want all 0",
               awready, wready, bvalid, bresp, arready, rvalid, rlast,
               rresp, rdata, wr_cnt, rd_cnt, err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release aw=%b ar=%b want 1/1", awready, arready);
    end
  endtask

  task automatic test_write_readback();
    for (int i = 0; i < 8; i++) begin
      wdat[i] = 32'(i + 1) * 32'h1111_1111;
      model[i] = wdat[i];
    end
    bq.push_back(2'b00);
    axi_write(32'h2000_0000, 8'd7, 3'b010, 2'b01, 4'hF, 8, 7);
    check_b(5);
    for (int i = 0; i < 8; i++) begin
      rq.push_back(model[i]);
      rsq.push_back(2'b00);
    end
    axi_read(32'h2000_0000, 8'd7, 2'b01, 1'b0);
  endtask

  task automatic test_strobe();
    wdat[0] = 32'h0;
    model[2] = 32'h0;
    bq.push_back(2'b00);
    axi_write(32'h2000_0008, 8'd0, 3'b010, 2'b01, 4'hF, 1, 0);
    check_b(1);
    wdat[0] = 32'hAABB_CCDD;
    model[2] = (model[2] & ~32'h00FF_00FF) | (wdat[0] & 32'h00FF_00FF);
    bq.push_back(2'b00);
    axi_write(32'h2000_0008, 8'd0, 3'b010, 2'b01, 4'b0101, 1, 0);
    check_b(1);
    rq.push_back(model[2]);
    rsq.push_back(2'b00);
    axi_read(32'h2000_0008, 8'd0, 2'b01, 1'b0);
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 4; i++) wdat[i] = 32'hC0DE_0000 + 32'(i);
    bq.push_back(2'b11);
    axi_write(32'h2000_0400, 8'd3, 3'b010, 2'b01, 4'hF, 4, 3);
    check_b(1);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL oor_sticky got=%b want=1", err);
    end
    for (int i = 0; i < 4; i++) begin
      rq.push_back(32'hDEAD_BEEF);
      rsq.push_back(2'b11);
    end
    axi_read(32'h2000_0400, 8'd3, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rq.push_back(model[i]);
      rsq.push_back(2'b00);
    end
    axi_read(32'h2000_0000, 8'd3, 2'b01, 1'b0);
  endtask

  task automatic test_protocol();
    wdat[0] = 32'h5555_AAAA;
    bq.push_back(2'b10);
    axi_write(32'h2000_0020, 8'd0, 3'b001, 2'b01, 4'hF, 1, 0);
    check_b(1);
    wdat[0] = 32'h0A0A_0A0A;
    wdat[1] = 32'h0B0B_0B0B;
    model[10] = wdat[0];
    model[11] = wdat[1];
    bq.push_back(2'b10);
    axi_write(32'h2000_0028, 8'd3, 3'b010, 2'b01, 4'hF, 2, 1);
    check_b(1);
    for (int i = 10; i < 12; i++) begin
      rq.push_back(model[i]);
      rsq.push_back(2'b00);
    end
    axi_read(32'h2000_0028, 8'd1, 2'b01, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rq.push_back(model[i]);
      rsq.push_back(2'b00);
    end
    axi_read(32'h2000_0000, 8'd7, 2'b01, 1'b1);
  endtask

  task automatic test_abort();
    for (int i = 0; i < 8; i++) wdat[i] = 32'hF00D_0010 + 32'(i);
    for (int i = 0; i < 3; i++) model[16 + i] = wdat[i];
    axi_write(32'h2000_0040, 8'd7, 3'b010, 2'b01, 4'hF, 3, -1);
    wdata = wdat[3]; wstrb = 4'hF; wvalid = 1'b1; rst = 1'b1;
    @(negedge clk);
    total++;
    if (wready !== 1'b0 || bvalid !== 1'b0) begin
      bad++;
      $display("FAIL abort_mask wready=%b bvalid=%b want 0/0", wready, bvalid);
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0; wvalid = 1'b0;
    exp_wr = 0; exp_rd = 0;
    @(negedge clk);
    total++;
    if (awready !== 1'b1 || arready !== 1'b1 || wready !== 1'b0 ||
        wr_cnt !== 16'h0 || rd_cnt !== 16'h0 || err !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle aw=%b ar=%b w=%b c=%0d/%0d e=%b want 1/1/0/0/0/0",
               awready, arready, wready, wr_cnt, rd_cnt, err);
    end
    repeat (3) begin
      @(negedge clk);
      total++;
      if (bvalid !== 1'b0) begin
        bad++;
        $display("FAIL abort_nob got=%b want=0", bvalid);
      end
    end
    for (int i = 16; i < 19; i++) begin
      rq.push_back(model[i]);
      rsq.push_back(2'b00);
    end
    axi_read(32'h2000_0040, 8'd2, 2'b01, 1'b0);
  endtask

  task automatic test_collision();
    logic [31:0] ed;
    rq.push_back(model[5]);
    rsq.push_back(2'b00);
    bq.push_back(2'b00);
    @(posedge clk); #1;
    awaddr = 32'h2000_0014; awlen = 8'd0; awsize = 3'b010; awburst = 2'b01;
    araddr = 32'h2000_0014; arlen = 8'd0; arsize = 3'b010; arburst = 2'b01;
    awvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    total++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      bad++;
      $display("FAIL coll_ready aw=%b ar=%b want 1/1", awready, arready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    wdata = 32'h1234_5678; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    rready = 1'b1;
    @(negedge clk);
    total++;
    if (wready !== 1'b1 || rvalid !== 1'b0) begin
      bad++;
      $display("FAIL coll_wbeat wready=%b rvalid=%b want 1/0", wready, rvalid);
    end
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk);
    ed = rq.pop_front();
    void'(rsq.pop_front());
    total++;
    if (rvalid !== 1'b1 || rdata !== ed || rlast !== 1'b1) begin
      bad++;
      $display("FAIL coll_read got=%b/%h/%b want=1/%h/1", rvalid, rdata, rlast, ed);
    end
    @(posedge clk); #1;
    rready = 1'b0;
    exp_rd++;
    model[5] = 32'h1234_5678;
    check_b(1);
    rq.push_back(model[5]);
    rsq.push_back(2'b00);
    axi_read(32'h2000_0014, 8'd0, 2'b01, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_strobe();
    test_out_of_range();
    test_protocol();
    test_abort();
    test_collision();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
